otter_intc: RTL and testbench

Multi-source interrupt controller for the OTTER MCU. It replaces the single INTR input with NUM_SRC synchronised sources, each with its own enable and its own level/edge mode, and fixed priority. It presents one INTR line to the CU FSM (gated by mstatus in the MCU top) and exposes claim/complete registers on the IOBUS. It handshakes with the CU via int_taken (INT_ACK) and mret_exec (MRET).

---
 rtl/otter_intc_if.sv | 20 ++
 rtl/otter_intc.sv | 113 +++++++++++
 tb/tb_otter_intc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_intc_if.sv
// otter_intc_if: IOBUS register access plus CU interrupt handshake for otter_intc
//   IO_ADDR/IO_WDATA/IO_WR : IOBUS write side (driven by the MCU)
//   IO_RDATA/IO_HIT        : combinational register read data and address-hit flag
//   INT_ACK/MRET           : CU int_taken / mret_exec pulses
//   INTR/CLAIM_ID          : interrupt request to the CU and in-service source id (0 = none)
interface otter_intc_if;
    logic [31:0] IO_ADDR;
    logic [31:0] IO_WDATA;
    logic        IO_WR;
    logic [31:0] IO_RDATA;
    logic        IO_HIT;
    logic        INT_ACK;
    logic        MRET;
    logic        INTR;
    logic [4:0]  CLAIM_ID;
    modport master (output IO_ADDR, IO_WDATA, IO_WR, INT_ACK, MRET,
                    input  IO_RDATA, IO_HIT, INTR, CLAIM_ID);
    modport slave  (input  IO_ADDR, IO_WDATA, IO_WR, INT_ACK, MRET,
                    output IO_RDATA, IO_HIT, INTR, CLAIM_ID);
endinterface

// File: rtl/otter_intc.sv
// otter_intc: multi-source fixed-priority interrupt controller for the OTTER MCU
//   CLK    : system clock, rising edge
//   RST    : asynchronous reset, active-low
//   IRQ_IN : asynchronous requests, bit 0 = highest priority
//   bus    : otter_intc_if.slave (IOBUS register block + CU INTR/INT_ACK/MRET/CLAIM_ID)
//   Optional macro OTTER_INTC_SWTRIG_EN adds the write-only SW_SET register at offset 0x14.
module otter_intc #(
    parameter int          NUM_SRC     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    otter_intc_if.slave        bus
);
`ifdef OTTER_INTC_SWTRIG_EN
    localparam logic [31:0] SPAN = 32'h18;
`else
    localparam logic [31:0] SPAN = 32'h14;
`endif
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q, prev_d, pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
    logic [4:0]         claim_q, claim_d, win_id, claim_rd;
    logic [31:0]        off, rd;
    logic [2:0]         word;
    logic               wr_en, unused_wdata;
    logic [NUM_SRC-1:0] synced, active, win_mask, set_v, clr_v, wdata;
    // Unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
    assign off          = bus.IO_ADDR - BASE_ADDR;
    assign bus.IO_HIT   = off < SPAN;
    assign word         = off[4:2];
    assign wr_en        = bus.IO_WR & bus.IO_HIT;
    assign wdata        = bus.IO_WDATA[NUM_SRC-1:0];
    assign unused_wdata = ^bus.IO_WDATA[31:NUM_SRC];
    assign synced       = sync_q[SYNC_STAGES-1];
    assign active       = pending_q & enable_q;
    // Two's-complement trick isolates the lowest set bit = highest-priority winner.
    assign win_mask     = active & (~active + NUM_SRC'(1));
    assign bus.INTR     = state_q == REQ;
    assign bus.CLAIM_ID = claim_q;
    assign claim_rd     = state_q == SERVICE ? claim_q : win_id;
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (active[i]) win_id = 5'(i + 1);
    end
    always_comb begin
        sync_d[0] = IRQ_IN;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        prev_d  = synced;
        set_v   = edge_q & synced & ~prev_q;
        clr_v   = (wr_en && word == 3'd0) ? wdata : '0;
`ifdef OTTER_INTC_SWTRIG_EN
        set_v   = set_v | ((wr_en && word == 3'd5) ? wdata : '0);
`endif
        state_d = state_q;
        claim_d = claim_q;
        case (state_q)
            IDLE:    if (|active) state_d = REQ;
            REQ:
                if (!(|active)) state_d = IDLE;
                else if (bus.INT_ACK) begin
                    state_d = SERVICE;
                    claim_d = win_id;
                    clr_v   = clr_v | win_mask;
                end
            SERVICE:
                if (bus.MRET || (wr_en && word == 3'd4)) begin
                    state_d = IDLE;
                    claim_d = '0;
                end
            default: state_d = IDLE;
        endcase
        // Edge bits: set beats clear; level bits simply follow the synchronised input.
        pending_d = (edge_q & (set_v | (pending_q & ~clr_v))) | (~edge_q & synced);
        enable_d  = (wr_en && word == 3'd1) ? wdata : enable_q;
        edge_d    = (wr_en && word == 3'd2) ? wdata : edge_q;
    end
    always_comb begin
        rd = '0;
        case (word)
            3'd0:    rd = 32'(pending_q);
            3'd1:    rd = 32'(enable_q);
            3'd2:    rd = 32'(edge_q);
            3'd3:    rd = 32'(claim_rd);
            default: rd = '0;
        endcase
        bus.IO_RDATA = bus.IO_HIT ? rd : '0;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q    <= '{default: '0};
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            claim_q   <= '0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            claim_q   <= claim_d;
            state_q   <= state_d;
        end
    end
endmodule

// File: tb/tb_otter_intc.sv
// tb_otter_intc: randomized and directed bench for otter_intc against a behavioural model
module tb_otter_intc;
    localparam int          N    = 8;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h1100_0100;
`ifdef OTTER_INTC_SWTRIG_EN
    localparam logic [31:0] TOP = 32'h18;
`else
    localparam logic [31:0] TOP = 32'h14;
`endif
    localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
    logic         CLK = 0, RST = 0;
    logic [N-1:0] irq = '0;
    int           checks = 0, failures = 0;
    otter_intc_if bus();
    otter_intc #(.NUM_SRC(N), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .CLK(CLK), .RST(RST), .IRQ_IN(irq), .bus(bus));
    always #5 CLK = ~CLK;
    logic [N-1:0] m_pend, m_en, m_edge;
    logic [N-1:0] smp[$];
    int           m_state;
    logic [4:0]   m_claim;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [4:0] m_win(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return 5'(i + 1);
        return 5'd0;
    endfunction
    function automatic bit m_hit(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o < TOP;
    endfunction
    function automatic int m_word(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o >> 2);
    endfunction
    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 0;
        case (m_word(a))
            0: return 32'(m_pend);
            1: return 32'(m_en);
            2: return 32'(m_edge);
            3: return m_state == M_SVC ? 32'(m_claim) : 32'(m_win(m_pend & m_en));
            default: return 0;
        endcase
    endfunction
    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_state = M_IDLE; m_claim = '0;
        smp = {};
        repeat (S + 1) smp.push_back('0);
    endtask
    // One clock edge of the controller, computed from the pre-edge inputs.
    task automatic model_step();
        logic [N-1:0] synced, prev, act, set, clr, wd;
        logic [4:0]   w;
        bit           wr;
        int           wrd;
        synced = smp[S-1];
        prev   = smp[S];
        act    = m_pend & m_en;
        w      = m_win(act);
        wr     = bus.IO_WR && m_hit(bus.IO_ADDR);
        wrd    = m_word(bus.IO_ADDR);
        wd     = bus.IO_WDATA[N-1:0];
        set    = '0;
        clr    = '0;
        for (int i = 0; i < N; i++) if (synced[i] && !prev[i]) set[i] = 1'b1;
        if (wr && wrd == 0) clr = wd;
`ifdef OTTER_INTC_SWTRIG_EN
        if (wr && wrd == 5) set = set | wd;
`endif
        if (m_state == M_IDLE) begin
            if (act != 0) m_state = M_REQ;
        end else if (m_state == M_REQ) begin
            if (act == 0) m_state = M_IDLE;
            else if (bus.INT_ACK) begin
                m_state = M_SVC;
                m_claim = w;
                clr[w-1] = 1'b1;
            end
        end else if (bus.MRET || (wr && wrd == 4)) begin
            m_state = M_IDLE;
            m_claim = '0;
        end
        for (int i = 0; i < N; i++)
            m_pend[i] = m_edge[i] ? (set[i] | (m_pend[i] & ~clr[i])) : synced[i];
        if (wr && wrd == 1) m_en = wd;
        if (wr && wrd == 2) m_edge = wd;
        smp.push_front(irq);
        void'(smp.pop_back());
    endtask
    task automatic tick();
        @(posedge CLK);
        if (!RST) model_reset(); else model_step();
        @(negedge CLK);
        check("intr", 32'(bus.INTR), 32'(m_state == M_REQ));
        check("claim_id", 32'(bus.CLAIM_ID), 32'(m_claim));
    endtask
    task automatic rd_model(input logic [31:0] a);
        bus.IO_ADDR = a;
        #1;
        check("rdata", bus.IO_RDATA, m_read(a));
        check("hit", 32'(bus.IO_HIT), 32'(m_hit(a)));
    endtask
    task automatic rd(input string tag, input logic [7:0] o, input logic [31:0] exp);
        bus.IO_ADDR = BASE + 32'(o);
        #1;
        check(tag, bus.IO_RDATA, exp);
    endtask
    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        bus.IO_ADDR = BASE + 32'(o); bus.IO_WDATA = d; bus.IO_WR = 1'b1;
        tick();
        bus.IO_WR = 1'b0;
    endtask
    task automatic ack();
        bus.INT_ACK = 1'b1; tick(); bus.INT_ACK = 1'b0;
    endtask
    task automatic wait_intr(input string tag);
        int n = 0;
        while (!bus.INTR && n < 20) begin tick(); n++; end
        check(tag, 32'(bus.INTR), 32'd1);
    endtask
    task automatic do_reset();
        irq = '0; bus.IO_WR = 0; bus.INT_ACK = 0; bus.MRET = 0; bus.IO_WDATA = '0;
        RST = 1'b0;
        model_reset();
        #1;
        check("rst_intr", 32'(bus.INTR), 0);
        check("rst_claim", 32'(bus.CLAIM_ID), 0);
        rd("rst_pend", 8'h00, 0);
        rd("rst_en", 8'h04, 0);
        tick();
        RST = 1'b1;
    endtask
    initial begin
        int n;
        bus.IO_ADDR = BASE;
        do_reset();
        // 1: level source latency, ack, re-request after MRET
        wr(8'h04, 32'h01);
        irq = 8'h01;
        n = 0;
        while (!bus.INTR && n < 20) begin tick(); n++; end
        check("t1_latency", n, S + 2);
        ack();
        check("t1_claim", 32'(bus.CLAIM_ID), 1);
        check("t1_intr_svc", 32'(bus.INTR), 0);
        bus.MRET = 1'b1; tick(); bus.MRET = 1'b0;
        check("t1_idle", 32'(bus.INTR), 0);
        tick();
        check("t1_rereq", 32'(bus.INTR), 1);
        // 2: two edge sources, priority and acceptance clear
        do_reset();
        wr(8'h08, 32'hFF); wr(8'h04, 32'hFF);
        irq = 8'h20; repeat (2) tick(); irq = 0; repeat (2) tick();
        irq = 8'h04; repeat (2) tick(); irq = 0; repeat (4) tick();
        rd("t2_claim_rd", 8'h0C, 3);
        ack();
        check("t2_claim_id", 32'(bus.CLAIM_ID), 3);
        rd("t2_pend", 8'h00, 32'h20);
        wr(8'h10, 32'h0);
        tick();
        check("t2_rereq", 32'(bus.INTR), 1);
        ack();
        check("t2_claim_id2", 32'(bus.CLAIM_ID), 6);
        // 3: withdrawal by disabling while in REQ
        do_reset();
        wr(8'h04, 32'h02);
        irq = 8'h02;
        wait_intr("t3_req");
        wr(8'h04, 32'h0);
        tick();
        check("t3_intr_drop", 32'(bus.INTR), 0);
        rd("t3_claim_rd", 8'h0C, 0);
        // 4: set beats W1C in the same edge
        do_reset();
        wr(8'h08, 32'h08);
        irq = 8'h08; repeat (4) tick(); irq = 0; repeat (3) tick();
        irq = 8'h08; repeat (S) tick();
        wr(8'h00, 32'h08);
        rd("t4_pend_set_wins", 8'h00, 32'h08);
        wr(8'h00, 32'h08);
        rd("t4_pend_w1c", 8'h00, 32'h00);
        // 5: no preemption during service
        do_reset();
        wr(8'h08, 32'hFE); wr(8'h04, 32'h09);
        irq = 8'h08; repeat (2) tick(); irq = 0;
        wait_intr("t5_req");
        ack();
        check("t5_claim4", 32'(bus.CLAIM_ID), 4);
        irq = 8'h01;
        for (int i = 0; i < 8; i++) begin tick(); check("t5_hold", 32'(bus.INTR), 0); end
        wr(8'h10, 32'h1234);
        tick();
        check("t5_rereq", 32'(bus.INTR), 1);
        ack();
        check("t5_claim1", 32'(bus.CLAIM_ID), 1);
        // 6: software trigger register
        do_reset();
        wr(8'h08, 32'h80); wr(8'h04, 32'h80); wr(8'h14, 32'h80);
`ifdef OTTER_INTC_SWTRIG_EN
        tick();
        check("t6_intr", 32'(bus.INTR), 1);
        rd("t6_claim_rd", 8'h0C, 8);
`else
        repeat (2) tick();
        check("t6_no_intr", 32'(bus.INTR), 0);
        rd("t6_rd14", 8'h14, 0);
        check("t6_hit14", 32'(bus.IO_HIT), 0);
`endif
        // Random traffic against the model, with one asynchronous reset mid-run
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [31:0] a;
            irq = irq ^ N'($urandom & $urandom & $urandom);
            a = ($urandom_range(0, 15) == 0) ? BASE - 32'(4 * $urandom_range(1, 4))
                                             : BASE + 32'($urandom_range(0, 31));
            rd_model(a);
            bus.IO_WDATA = $urandom;
            bus.IO_WR    = $urandom_range(0, 4) == 0;
            bus.INT_ACK  = $urandom_range(0, 3) == 0;
            bus.MRET     = $urandom_range(0, 7) == 0;
            if (c == 400) begin
                RST = 1'b0;
                model_reset();
                #1;
                check("mid_rst_intr", 32'(bus.INTR), 0);
                check("mid_rst_claim", 32'(bus.CLAIM_ID), 0);
                rd_model(BASE);
                tick();
                RST = 1'b1;
            end else tick();
            bus.IO_WR = 0; bus.INT_ACK = 0; bus.MRET = 0;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
